// File: rtl/branch_tracker.sv
// branch_tracker: circular buffer of in-flight conditional branch predictions.
// Entries are allocated in order, resolved out of order by tag, and committed
// in order. Each commit drives a one-cycle predictor update on the br_* port.
module branch_tracker #(
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned IDX_BITS       = 3,
  parameter int unsigned PRED_TABLE_BIT = 6
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      alloc_valid,
  input  logic                      alloc_pred,
  input  logic [PRED_TABLE_BIT-1:0] alloc_g_ind,
  input  logic [PRED_TABLE_BIT-1:0] alloc_l_ind,
  output logic                      alloc_ready,
  output logic [IDX_BITS-1:0]       alloc_tag,
  input  logic                      res_valid,
  input  logic [IDX_BITS-1:0]       res_tag,
  input  logic                      res_taken,
  input  logic                      commit_valid,
  output logic                      head_resolved,
  input  logic                      flush_in,
  output logic                      br_req,
  output logic                      br_correct,
  output logic [31:0]               br_res,
  output logic [PRED_TABLE_BIT-1:0] br_g_ind,
  output logic [PRED_TABLE_BIT-1:0] br_l_ind,
  output logic                      mispredict_out,
  output logic [IDX_BITS:0]         count_out
);

  localparam int unsigned CNT_W = IDX_BITS + 1;
  localparam logic [CNT_W-1:0]    FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_BITS-1:0] IDX_ONE  = IDX_BITS'(1);

  // Per-entry prediction metadata
  typedef struct packed {
    logic                      pred;
    logic                      taken;
    logic [PRED_TABLE_BIT-1:0] g_ind;
    logic [PRED_TABLE_BIT-1:0] l_ind;
  } br_meta_t;

  br_meta_t             meta_q [DEPTH];
  logic [DEPTH-1:0]     valid_q;
  logic [DEPTH-1:0]     resolved_q;
  logic [DEPTH-1:0]     valid_d;
  logic [DEPTH-1:0]     resolved_d;
  logic [IDX_BITS-1:0]  head_q;
  logic [IDX_BITS-1:0]  tail_q;
  logic [CNT_W-1:0]     count_q;

  logic alloc_fire;
  logic res_fire;
  logic commit_fire;
  logic upd_en;
  br_meta_t head_meta;

  // Handshake status derived from registered state only
  assign alloc_ready   = (count_q != FULL_CNT);
  assign alloc_tag     = tail_q;
  assign head_resolved = (count_q != '0) && resolved_q[head_q];
  assign count_out     = count_q;
  assign head_meta     = meta_q[head_q];

  // Event qualification; a flush or stall suppresses every other event
  assign upd_en      = rdy_in && !flush_in;
  assign alloc_fire  = upd_en && alloc_valid && alloc_ready;
  assign res_fire    = upd_en && res_valid && valid_q[res_tag];
  assign commit_fire = upd_en && commit_valid && head_resolved;

  // Next valid/resolved vectors; alloc and commit never touch the same slot
  always_comb begin
    valid_d    = valid_q;
    resolved_d = resolved_q;
    if (commit_fire) begin
      valid_d[head_q] = 1'b0;
    end
    if (alloc_fire) begin
      valid_d[tail_q]    = 1'b1;
      resolved_d[tail_q] = 1'b0;
    end
    if (res_fire) begin
      resolved_d[res_tag] = 1'b1;
    end
  end

  // Entry status bits
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid_q    <= '0;
      resolved_q <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        valid_q    <= '0;
        resolved_q <= '0;
      end else begin
        valid_q    <= valid_d;
        resolved_q <= resolved_d;
      end
    end
  end

  // Entry metadata: prediction written at alloc, direction written at resolve
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        meta_q[i] <= '0;
      end
    end else begin
      if (alloc_fire) begin
        meta_q[tail_q] <= '{pred: alloc_pred, taken: 1'b0,
                            g_ind: alloc_g_ind, l_ind: alloc_l_ind};
      end
      if (res_fire) begin
        meta_q[res_tag].taken <= res_taken;
      end
    end
  end

  // Head/tail pointers and occupancy
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (alloc_fire) begin
          tail_q <= tail_q + IDX_ONE;
        end
        if (commit_fire) begin
          head_q <= head_q + IDX_ONE;
        end
        unique case ({alloc_fire, commit_fire})
          2'b10:   count_q <= count_q + CNT_ONE;
          2'b01:   count_q <= count_q - CNT_ONE;
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // Predictor update port: one-cycle strobe after each commit, payload holds
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      br_req         <= 1'b0;
      br_correct     <= 1'b0;
      br_res         <= '0;
      br_g_ind       <= '0;
      br_l_ind       <= '0;
      mispredict_out <= 1'b0;
    end else if (rdy_in) begin
      if (commit_fire) begin
        br_req         <= 1'b1;
        br_correct     <= (head_meta.taken == head_meta.pred);
        br_res         <= 32'(head_meta.taken);
        br_g_ind       <= head_meta.g_ind;
        br_l_ind       <= head_meta.l_ind;
        mispredict_out <= (head_meta.taken != head_meta.pred);
      end else begin
        br_req         <= 1'b0;
        mispredict_out <= 1'b0;
      end
    end
  end

endmodule
